// File: rtl/usb_rx_timer.sv
// USB receive bit timer: phase counter, sample-point strobes, bit/byte counting; USB_RX_BIT_STUFF_EN adds destuffing.
// Latency: shift_strobe/byte_done/stuff_err are registered, one edge after the sample-point cycle.
// Backpressure: none; the timer free-runs while enable is high, and dropping enable discards any partial byte.
module usb_rx_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    input  logic       resync,
    input  logic       rx_bit,
    output logic       shift_strobe,
    output logic       byte_done,
    output logic [2:0] bit_index,
    output logic       stuff_err
);

    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_POINT);
    localparam logic [PW-1:0] PHASE_RESYNC = PW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [2:0]      bit_index_q, bit_index_d;
    logic            strobe_q, strobe_d;
    logic            byte_done_q, byte_done_d;
    logic            sample;
    logic            take;

    assign sample = (state_q == RUN) && enable && (phase_q == PHASE_SAMPLE) && !resync;

`ifdef USB_RX_BIT_STUFF_EN
    logic [2:0] ones_q, ones_d;
    logic       stuff_err_q, stuff_err_d;
    logic       stuff_bit;

    // After six consecutive ones the next sampled bit is a stuff bit, never data.
    assign stuff_bit = sample && (ones_q == 3'd6);
    assign take      = sample && !stuff_bit;

    always_comb begin
        ones_d      = ones_q;
        stuff_err_d = 1'b0;
        if (state_q == IDLE || !enable) begin
            ones_d = 3'd0;
        end else if (stuff_bit) begin
            ones_d      = 3'd0;
            stuff_err_d = rx_bit;
        end else if (take) begin
            ones_d = rx_bit ? ones_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_q      <= 3'd0;
            stuff_err_q <= 1'b0;
        end else begin
            ones_q      <= ones_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    assign stuff_err = stuff_err_q;
`else
    logic unused_rx_bit;

    assign unused_rx_bit = rx_bit;
    assign take          = sample;
    assign stuff_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_index_d = bit_index_q;
        strobe_d    = 1'b0;
        byte_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d     = '0;
                bit_index_d = 3'd0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d     = IDLE;
                    phase_d     = '0;
                    bit_index_d = 3'd0;
                end else begin
                    // The resync edge itself counts as phase 0.
                    if (resync) begin
                        phase_d = PHASE_RESYNC;
                    end else if (phase_q == PHASE_LAST) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                    if (take) begin
                        strobe_d    = 1'b1;
                        byte_done_d = (bit_index_q == 3'd7);
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            bit_index_q <= 3'd0;
            strobe_q    <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_index_q <= bit_index_d;
            strobe_q    <= strobe_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign shift_strobe = strobe_q;
    assign byte_done    = byte_done_q;
    assign bit_index    = bit_index_q;

endmodule

// File: tb/tb_usb_rx_timer.sv
// Self-checking bench for usb_rx_timer: directed scenarios plus random traffic against a cycle-count reference model.
module tb_usb_rx_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
`ifdef USB_RX_BIT_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       enable = 1'b0;
    logic       resync = 1'b0;
    logic       rx_bit = 1'b0;
    logic       shift_strobe;
    logic       byte_done;
    logic [2:0] bit_index;
    logic       stuff_err;

    usb_rx_timer #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .resync       (resync),
        .rx_bit       (rx_bit),
        .shift_strobe (shift_strobe),
        .byte_done    (byte_done),
        .bit_index    (bit_index),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       strobe;
        logic       bdone;
        logic       serr;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: cycles elapsed since the last alignment point, data bits in the byte, run of ones.
    bit m_run  = 1'b0;
    int m_cyc  = 0;
    int m_bits = 0;
    int m_ones = 0;

    function automatic exp_t model_step(input bit rst_ok, input bit en, input bit rs, input bit b);
        exp_t e;
        bit   smp;
        e = '0;
        if (!rst_ok || !m_run || !en) begin
            m_run  = rst_ok && en;
            m_cyc  = 0;
            m_bits = 0;
            m_ones = 0;
        end else begin
            smp   = ((m_cyc % CPB) == SP) && !rs;
            m_cyc = rs ? 1 : m_cyc + 1;
            if (smp) begin
                if (STUFF && m_ones == 6) begin
                    e.serr = b;
                    m_ones = 0;
                end else begin
                    e.strobe = 1'b1;
                    e.bdone  = (m_bits == 7);
                    m_bits   = (m_bits + 1) % 8;
                    m_ones   = b ? m_ones + 1 : 0;
                end
            end
        end
        e.idx = m_bits[2:0];
        return e;
    endfunction

    task automatic step(input bit en, input bit rs, input bit b);
        exp_t e;
        enable = en;
        resync = rs;
        rx_bit = b;
        e = model_step(n_rst, en, rs, b);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic steps(input int n, input bit en, input bit b);
        for (int i = 0; i < n; i++) step(en, 1'b0, b);
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({shift_strobe, byte_done, stuff_err, bit_index} !== 6'b0) begin
            n_fail++;
            $display("FAIL %s: got strobe=%b bdone=%b serr=%b idx=%0d, expected all zero",
                     name, shift_strobe, byte_done, stuff_err, bit_index);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check_zero("async_reset");
    endtask

    // Monitor: one expected entry per clock edge, compared away from the edge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {shift_strobe, byte_done, stuff_err, bit_index};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL cycle t=%0t: got strobe=%b bdone=%b serr=%b idx=%0d, expected strobe=%b bdone=%b serr=%b idx=%0d",
                             $time, got.strobe, got.bdone, got.serr, got.idx, e.strobe, e.bdone, e.serr, e.idx);
                end
            end
        end
    end

    initial begin
        bit pattern [8];
        int budget;
        pattern = '{1, 1, 1, 1, 1, 1, 0, 1};

        #1 n_rst = 1'b0;
        #1 check_zero("reset_state");
        steps(2, 1'b0, 1'b0);
        n_rst = 1'b1;
        steps(2, 1'b0, 1'b0);

        // Full byte of zeros: strobes at edges 4..60 after entry.
        step(1'b1, 1'b0, 1'b0);
        steps(64, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Resync at phase 6.
        step(1'b1, 1'b0, 1'b0);
        steps(6, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        steps(20, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Six ones then a zero.
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) steps(CPB, 1'b1, pattern[i]);
        step(1'b0, 1'b0, 1'b0);

        // Seven consecutive ones, then a zero.
        step(1'b1, 1'b0, 1'b1);
        steps(7 * CPB, 1'b1, 1'b1);
        steps(CPB, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Enable dropped on the sample point of the sixth bit, then re-entry.
        step(1'b1, 1'b0, 1'b0);
        steps(43, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        steps(16, 1'b1, 1'b1);

        // Asynchronous reset mid-byte, IDLE held until enable returns.
        steps(20, 1'b1, 1'b0);
        async_reset();
        steps(2, 1'b1, 1'b0);
        n_rst = 1'b1;
        steps(3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        steps(12, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75);
        end
        step(1'b0, 1'b0, 1'b0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
